// File: rtl/object_update_arbiter.sv
// object_update_arbiter: round-robin writes into a shadow object file,
// copied to the active file on frame start so the display never tears.
module object_update_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_OBJ  = 8,
    parameter int OBJ_W    = 3,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int SIZE_MAX = 31
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_start,
    input  logic                     freeze,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*OBJ_W-1:0] wr_obj,
    input  logic [NUM_REQ*10-1:0]    wr_x,
    input  logic [NUM_REQ*10-1:0]    wr_y,
    input  logic [NUM_REQ*10-1:0]    wr_size,
    input  logic [NUM_REQ-1:0]       wr_vis,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_OBJ*10-1:0]    obj_x,
    output logic [NUM_OBJ*10-1:0]    obj_y,
    output logic [NUM_OBJ*10-1:0]    obj_size,
    output logic [NUM_OBJ-1:0]       obj_vis,
    output logic                     dirty,
    output logic                     committed
);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [9:0] XM = 10'(X_MAX);
    localparam logic [9:0] YM = 10'(Y_MAX);
    localparam logic [9:0] SM = 10'(SIZE_MAX);

    logic [PW-1:0]         ptr, gnt;
    logic                  hit, commit;
    logic [NUM_REQ-1:0]    elig;
    logic [OBJ_W-1:0]      g_obj;
    logic [9:0]            g_x, g_y, g_size;
    logic [NUM_OBJ*10-1:0] sh_x, sh_y, sh_size;
    logic [NUM_OBJ-1:0]    sh_vis;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v >= NUM_REQ ? v - NUM_REQ : v);
    endfunction

    // a requester whose ack is showing is masked so it cannot be granted twice
    assign elig   = req & ~ack;
    assign commit = frame_start & dirty & ~freeze;
    assign g_obj  = wr_obj[int'(gnt)*OBJ_W +: OBJ_W];
    assign g_x    = wr_x[int'(gnt)*10 +: 10];
    assign g_y    = wr_y[int'(gnt)*10 +: 10];
    assign g_size = wr_size[int'(gnt)*10 +: 10];

    always_comb begin
        gnt = ptr;
        hit = 1'b0;
        for (int k = 0; k < NUM_REQ; k++)
            if (!hit && !frame_start && elig[wrap(int'(ptr) + k)]) begin
                gnt = wrap(int'(ptr) + k);
                hit = 1'b1;
            end
    end

    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            ptr       <= '0;
            ack       <= '0;
            dirty     <= 1'b0;
            committed <= 1'b0;
            sh_x      <= '0;
            sh_y      <= '0;
            sh_size   <= '0;
            sh_vis    <= '0;
            obj_x     <= '0;
            obj_y     <= '0;
            obj_size  <= '0;
            obj_vis   <= '0;
        end else begin
            ack       <= hit ? NUM_REQ'(1) << gnt : '0;
            committed <= commit;
            dirty     <= hit | (dirty & ~commit);
            if (hit) begin
                ptr                          <= wrap(int'(gnt) + 1);
                sh_x[int'(g_obj)*10 +: 10]    <= g_x > XM ? XM : g_x;
                sh_y[int'(g_obj)*10 +: 10]    <= g_y > YM ? YM : g_y;
                sh_size[int'(g_obj)*10 +: 10] <= g_size > SM ? SM : g_size;
                sh_vis[g_obj]                 <= wr_vis[gnt];
            end
            if (commit) begin
                obj_x    <= sh_x;
                obj_y    <= sh_y;
                obj_size <= sh_size;
                obj_vis  <= sh_vis;
            end
        end
endmodule

// File: tb/tb_object_update_arbiter.sv
// tb_object_update_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a slot-array model of the arbiter.
module tb_object_update_arbiter;
    localparam int N = 4, M = 8;

    logic Clk = 1'b0, Reset_n = 1'b0, frame_start = 1'b0, freeze = 1'b0;
    logic [N-1:0] req = '0, wr_vis = '0, ack;
    logic [N*3-1:0] wr_obj = '0;
    logic [N*10-1:0] wr_x = '0, wr_y = '0, wr_size = '0;
    logic [M*10-1:0] obj_x, obj_y, obj_size;
    logic [M-1:0] obj_vis;
    logic dirty, committed;
    int tests = 0, fails = 0;

    object_update_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .freeze(freeze),
        .req(req), .wr_obj(wr_obj), .wr_x(wr_x), .wr_y(wr_y), .wr_size(wr_size),
        .wr_vis(wr_vis), .ack(ack), .obj_x(obj_x), .obj_y(obj_y),
        .obj_size(obj_size), .obj_vis(obj_vis), .dirty(dirty), .committed(committed)
    );

    always #5 Clk = ~Clk;

    // model: shadow/active slot arrays, pointer and last-cycle grant
    int m_ptr, sx[M], sy[M], ss[M], ax[M], ay[M], as_[M];
    bit sv[M], av[M];
    bit [N-1:0] m_ack;
    bit m_dirty, m_comm;

    function automatic int cap(int v, int lim);
        return v > lim ? lim : v;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        int g, o;
        bit c;
        if (!Reset_n) begin
            m_ptr = 0; m_ack = '0; m_dirty = 0; m_comm = 0;
            for (int s = 0; s < M; s++) begin
                sx[s] = 0; sy[s] = 0; ss[s] = 0; sv[s] = 0;
                ax[s] = 0; ay[s] = 0; as_[s] = 0; av[s] = 0;
            end
        end else begin
            g = -1;
            c = frame_start && m_dirty && !freeze;
            if (!frame_start)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req[(m_ptr + k) % N] && !m_ack[(m_ptr + k) % N])
                        g = (m_ptr + k) % N;
            if (c) begin
                for (int s = 0; s < M; s++) begin
                    ax[s] = sx[s]; ay[s] = sy[s]; as_[s] = ss[s]; av[s] = sv[s];
                end
                m_dirty = 0;
            end
            m_ack = '0;
            if (g >= 0) begin
                o = int'(wr_obj[g*3 +: 3]);
                sx[o] = cap(int'(wr_x[g*10 +: 10]), 639);
                sy[o] = cap(int'(wr_y[g*10 +: 10]), 479);
                ss[o] = cap(int'(wr_size[g*10 +: 10]), 31);
                sv[o] = wr_vis[g];
                m_ack[g] = 1'b1;
                m_dirty = 1;
                m_ptr = (g + 1) % N;
            end
            m_comm = c;
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        logic [M*10-1:0] ex, ey, es;
        logic [M-1:0] ev;
        for (int s = 0; s < M; s++) begin
            ex[s*10 +: 10] = 10'(ax[s]); ey[s*10 +: 10] = 10'(ay[s]);
            es[s*10 +: 10] = 10'(as_[s]); ev[s] = av[s];
        end
        chk("model_ack", 128'(ack), 128'(m_ack));
        chk("model_obj_x", 128'(obj_x), 128'(ex));
        chk("model_obj_y", 128'(obj_y), 128'(ey));
        chk("model_obj_size", 128'(obj_size), 128'(es));
        chk("model_obj_vis", 128'(obj_vis), 128'(ev));
        chk("model_dirty", 128'(dirty), 128'(m_dirty));
        chk("model_committed", 128'(committed), 128'(m_comm));
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic put(input int i, input int o, input int x, input int y, input int s, input bit v);
        wr_obj[i*3 +: 3] = 3'(o); wr_x[i*10 +: 10] = 10'(x);
        wr_y[i*10 +: 10] = 10'(y); wr_size[i*10 +: 10] = 10'(s);
        wr_vis[i] = v; req[i] = 1'b1;
    endtask

    task automatic pulse_frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic rnd_cycle;
        for (int i = 0; i < N; i++)
            if (req[i] && ack[i]) begin
                if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                else put(i, $urandom_range(7, 0), $urandom_range(1023, 0),
                         $urandom_range(1023, 0), $urandom_range(63, 0), 1'($urandom));
            end else if (!req[i] && $urandom_range(2, 0) == 0)
                put(i, $urandom_range(7, 0), $urandom_range(1023, 0),
                    $urandom_range(1023, 0), $urandom_range(63, 0), 1'($urandom));
        frame_start = ($urandom_range(11, 0) == 0) || (frame_start && $urandom_range(2, 0) == 0);
        freeze = $urandom_range(7, 0) == 0;
        tick();
    endtask

    task automatic clr;
        req = '0; frame_start = 1'b0; freeze = 1'b0;
    endtask

    initial begin
        tick(); tick();
        Reset_n = 1'b1;
        repeat (60) rnd_cycle();
        Reset_n = 1'b0;
        #1;
        chk("rst_ack", 128'(ack), 128'(0));
        chk("rst_obj_x", 128'(obj_x), 128'(0));
        chk("rst_obj_vis", 128'(obj_vis), 128'(0));
        chk("rst_dirty", 128'(dirty), 128'(0));
        chk("rst_committed", 128'(committed), 128'(0));
        clr();
        tick();
        Reset_n = 1'b1;

        for (int i = 0; i < N; i++) put(i, i, 11 * (i + 1), 7 * (i + 1), i + 1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_ack", 128'(ack), 128'(4'b0001 << (k % 4)));
        end
        clr();
        put(2, 3, 100, 200, 8, 1'b1);
        tick();
        chk("lat_ack", 128'(ack), 128'(4'b0100));
        chk("lat_dirty", 128'(dirty), 128'(1));
        clr();
        chk("pre_commit_x3", 128'(obj_x[30 +: 10]), 128'(0));
        tick();
        pulse_frame();
        chk("commit_x3", 128'(obj_x[30 +: 10]), 128'(100));
        chk("commit_y3", 128'(obj_y[30 +: 10]), 128'(200));
        chk("commit_size3", 128'(obj_size[30 +: 10]), 128'(8));
        chk("commit_pulse", 128'(committed), 128'(1));
        chk("commit_dirty", 128'(dirty), 128'(0));
        tick();
        chk("commit_pulse_end", 128'(committed), 128'(0));

        put(0, 1, 700, 500, 40, 1'b1);
        tick();
        clr();
        pulse_frame();
        chk("clamp_x", 128'(obj_x[10 +: 10]), 128'(639));
        chk("clamp_y", 128'(obj_y[10 +: 10]), 128'(479));
        chk("clamp_size", 128'(obj_size[10 +: 10]), 128'(31));

        put(1, 6, 300, 150, 5, 1'b1);
        frame_start = 1'b1;
        tick();
        chk("coin_no_ack", 128'(ack), 128'(0));
        chk("coin_no_commit", 128'(committed), 128'(0));
        frame_start = 1'b0;
        tick();
        chk("coin_ack", 128'(ack), 128'(4'b0010));
        chk("coin_dirty", 128'(dirty), 128'(1));
        clr();
        pulse_frame();
        chk("coin_commit_x6", 128'(obj_x[60 +: 10]), 128'(300));

        freeze = 1'b1;
        put(0, 0, 50, 1, 1, 1'b0);
        tick();
        req = '0;
        pulse_frame();
        chk("frz_x0", 128'(obj_x[0 +: 10]), 128'(11));
        chk("frz_dirty", 128'(dirty), 128'(1));
        chk("frz_committed", 128'(committed), 128'(0));
        freeze = 1'b0;
        pulse_frame();
        chk("unfrz_x0", 128'(obj_x[0 +: 10]), 128'(50));

        put(0, 5, 10, 0, 0, 1'b1);
        tick();
        clr();
        put(3, 5, 20, 0, 0, 1'b1);
        tick();
        chk("lww_ack3", 128'(ack), 128'(4'b1000));
        clr();
        pulse_frame();
        chk("lww_x5", 128'(obj_x[50 +: 10]), 128'(20));

        repeat (3000) rnd_cycle();
        clr();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/object_update_arbiter.md
Name: object_update_arbiter

Overview:
- Shares the on-screen object coordinate registers (X, Y, size, visible) between several game-logic requesters: snake controllers, food spawner, projectile logic.
- Accepts writes through a round-robin req/ack handshake into a shadow register file.
- Copies the shadow file to the active file once per frame, at the frame-start pulse.
- The color mapper reads only the active file, so coordinates never change mid-frame and there is no tearing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_OBJ, 8, number of object slots (power of two, 2..16).
- OBJ_W, 3, object index width; must equal log2(NUM_OBJ).
- X_MAX, 639, largest legal X coordinate.
- Y_MAX, 479, largest legal Y coordinate.
- SIZE_MAX, 31, largest legal object half-size.

Ports:
- Clk  in  1  system clock (pixel-domain 25 MHz clock).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- freeze  in  1  level; when high, commits are suppressed (game paused).
- req  in  NUM_REQ  per-requester write request.
- wr_obj  in  NUM_REQ*OBJ_W  per-requester target slot.
- wr_x  in  NUM_REQ*10  per-requester X.
- wr_y  in  NUM_REQ*10  per-requester Y.
- wr_size  in  NUM_REQ*10  per-requester half-size.
- wr_vis  in  NUM_REQ  per-requester visible bit.
- ack  out  NUM_REQ  one-cycle write-accepted pulse.
- obj_x  out  NUM_OBJ*10  active X per slot.
- obj_y  out  NUM_OBJ*10  active Y per slot.
- obj_size  out  NUM_OBJ*10  active half-size per slot.
- obj_vis  out  NUM_OBJ  active visible bit per slot.
- dirty  out  1  shadow differs from active (at least one write since last commit).
- committed  out  1  one-cycle pulse, cycle after a commit.

Behaviour:
- **Reset (async, Reset_n low):**
  - All shadow and active fields, ack, dirty and committed = 0.
  - Round-robin pointer = 0.
  - Outputs valid immediately on reset assertion.
- **Eligibility:** requester i is eligible when req[i]=1 and ack[i]=0. Because ack is registered, this prevents a double grant in the cycle the requester sees its ack.
- **Arbitration:**
  - Each cycle, at most one eligible requester is granted.
  - Search order starts at the pointer and wraps around.
  - On a grant to i, pointer <= (i+1) mod NUM_REQ; otherwise the pointer holds.
- **Grant action (at the edge):**
  - Shadow slot wr_obj[i] <= {clamped x, clamped y, clamped size, wr_vis[i]}.
  - ack[i] <= 1 for exactly one cycle; dirty <= 1.
- **Handshake:**
  - Requester holds req and data stable until it sees ack=1.
  - Requester may drop req or present new data in the ack cycle; new data is eligible from the following cycle.
  - Latency from req sampled (when first in priority) to ack visible is 1 cycle.
- **Clamping (unsigned):**
  - x > X_MAX stores X_MAX.
  - y > Y_MAX stores Y_MAX.
  - size > SIZE_MAX stores SIZE_MAX.
  - No other arithmetic on the data.
- **Same slot, consecutive cycles:** each write is applied in grant order; the last write wins.
- **frame_start cycle:**
  - No grant; the arbiter stalls and the pointer holds.
  - If dirty=1 and freeze=0: active <= shadow (all slots, single edge), dirty <= 0, committed <= 1 next cycle.
  - If freeze=1 or dirty=0: no copy, dirty unchanged, committed stays 0.
- **Coincident request:** a request pending during frame_start is granted on a later cycle and lands in the next frame.
- **Back-to-back pulses:** frame_start on consecutive cycles is legal; each pulse is evaluated independently.
- **Outputs:** active outputs change only on a commit edge (or reset).
- **Reset mid-handshake:** in-flight writes are discarded; the requester must re-request.
- **Implementation:** registered outputs, no combinational path from inputs to outputs.

Test Plan:
- **Reset:** assert Reset_n=0 mid-operation -> all outputs 0 asynchronously, pointer 0; after release, req[2] with slot 3, x=100, y=200, size=8 -> ack[2] 1 cycle later; obj_x[3] stays 0 until frame_start, then 100/200/8 and committed pulses.
- **Round-robin:** hold req=4'b1111 with distinct data -> acks in order 0,1,2,3,0, one per cycle; ack[i] never high 2 consecutive cycles.
- **Clamping:** x=700, y=500, size=40 -> active after commit shows 639, 479, 31.
- **Coincidence:** req[1] asserted same cycle as frame_start with dirty=0 -> no grant that cycle, no commit, ack[1] next cycle, dirty=1; next frame_start commits it.
- **Freeze:** freeze=1, write slot 0 x=50, frame_start -> active unchanged, dirty stays 1, no committed pulse; freeze=0, next frame_start -> obj_x[0]=50.
- **Last write wins:** req[0] then req[3] both target slot 5 with x=10 then x=20 before frame_start -> obj_x[5]=20 after commit.
